// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-level round-robin arbiter feeding one UART tx FIFO.
// Optional header byte carries the owning source index.
module uart_tx_arb #(
  parameter int NREQ   = 4,
  parameter int DBIT   = 8,
  parameter int LEN_W  = 4,
  parameter int HDR_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ-1:0]       src_valid,
  input  logic [NREQ*DBIT-1:0]  src_data,
  output logic [NREQ-1:0]       src_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  wr_en,
  output logic [DBIT-1:0]       wr_data,
  input  logic                  tx_full
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [NREQ-1:0]   grant_q;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     last;
  logic [IW-1:0]     win;
  logic              found;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic              done_q;
  logic              fin;
  logic [LEN_W-1:0]  len_a [NREQ];
  logic [DBIT-1:0]   dat_a [NREQ];

  // Unpack the per-source length and data buses.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      len_a[i] = req_len[i*LEN_W +: LEN_W];
      dat_a[i] = src_data[i*DBIT +: DBIT];
    end
  end

  // Round-robin scan: first requester after the last owner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = int'(last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and the UART write / source handshake outputs.
  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    wr_data   = '0;
    src_ready = '0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && grant_q == '0 && len_a[win] != '0)
          state_nx = (HDR_EN != 0) ? HDR : DATA;
      end
      HDR: begin
        wr_en   = !tx_full;
        wr_data = DBIT'(gidx);
        if (!tx_full) state_nx = DATA;
      end
      DATA: begin
        src_ready[gidx] = !tx_full;
        wr_en           = src_valid[gidx] && !tx_full;
        wr_data         = dat_a[gidx];
        if (wr_en && cnt == len - LEN_W'(1)) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grant, pointer, length latch, byte counter and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      gidx    <= '0;
      last    <= IW'(NREQ - 1);
      len     <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (grant_q != '0) begin
          grant_q <= '0;
        end else if (found) begin
          grant_q <= NREQ'(1) << win;
          gidx    <= win;
          len     <= len_a[win];
          if (len_a[win] == '0) begin
            done_q <= 1'b1;
            last   <= win;
          end
        end
      end else if (state == DATA && wr_en) begin
        if (fin) begin
          cnt     <= '0;
          done_q  <= 1'b1;
          last    <= gidx;
          grant_q <= '0;
        end else begin
          cnt <= cnt + LEN_W'(1);
        end
      end
    end
  end

  assign grant    = grant_q;
  assign busy     = (state != IDLE);
  assign pkt_done = done_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized bench against a packet-level model
// of round-robin order and the expected UART byte stream.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        pkt_done;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        tx_full;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .NREQ(4), .DBIT(8), .LEN_W(4), .HDR_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len),
    .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .grant(grant), .busy(busy),
    .pkt_done(pkt_done), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] payload [4][256];
  int ptr [4];
  int mptr [4];

  int model_last;
  int own;
  int own_len;
  bit hdr_pend;
  int remaining;
  bit done_due;
  logic [7:0] expq [$];

  int drop_mode;
  bit bp_burst;
  int bp_left;
  int stop_pw;
  int pkt_wr;
  int n_writes;
  int first_wr;
  int last_wr;
  int prev_last_wr;
  int min_turn;
  int max_turn;
  int full_seen;
  int first_grant_iter;
  int first_w;

  function automatic int rr_pick(int lst, logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (lst + k) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++)
      src_data[i*8 +: 8] = payload[i][ptr[i] & 255];
  endtask

  task automatic model_reset();
    model_last = 3;
    own = -1;
    own_len = 0;
    hdr_pend = 0;
    remaining = 0;
    done_due = 0;
    expq.delete();
    for (int i = 0; i < 4; i++) mptr[i] = ptr[i];
  endtask

  task automatic set_lens(input int l0, input int l1,
                          input int l2, input int l3);
    req_len = {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
  endtask

  task automatic run(input int npkts, input int tail,
                     input int full_pct, input int gap_pct);
    int dones;
    int after;
    int it;
    bit exp_done;
    bit exp_busy;
    bit exp_wr;
    logic [3:0] oh;
    logic [3:0] exp_ready;
    logic [7:0] e;
    dones = 0;
    after = 0;
    it = 0;
    n_writes = 0;
    first_wr = -1;
    last_wr = -1;
    prev_last_wr = -1;
    min_turn = 1000000;
    max_turn = 0;
    full_seen = 0;
    first_grant_iter = -1;
    first_w = -1;
    pkt_wr = 0;
    while ((dones < npkts || after < tail) && it < 4000) begin
      @(posedge clk);
      #1;
      if (bp_left > 0) begin
        tx_full = 1'b1;
        bp_left--;
        full_seen++;
      end else begin
        tx_full = ($urandom_range(99) < full_pct);
      end
      for (int i = 0; i < 4; i++)
        src_valid[i] = ($urandom_range(99) >= gap_pct);
      drive_srcs();
      @(negedge clk);
      it++;
      if (dones >= npkts) after++;
      exp_done = done_due;
      done_due = 0;
      if (own < 0 && grant != 4'b0) begin
        int w;
        w = rr_pick(model_last, req);
        checks++;
        oh = (w >= 0) ? (4'b0001 << w) : 4'b0;
        if (grant !== oh) begin
          failures++;
          $display("FAIL arb_order: grant=%b want=%b", grant, oh);
        end
        if (w < 0) w = 0;
        if (first_grant_iter < 0) first_grant_iter = it - 1;
        if (first_w < 0) first_w = w;
        own = w;
        own_len = int'(req_len[w*4 +: 4]);
        model_last = w;
        remaining = own_len;
        hdr_pend = (own_len != 0);
        pkt_wr = 0;
        if (own_len != 0) begin
          expq.push_back(8'(w));
          for (int k = 0; k < own_len; k++)
            expq.push_back(payload[w][(mptr[w] + k) & 255]);
          mptr[w] += own_len;
        end else begin
          exp_done = 1;
        end
        if (drop_mode == 1) req[w] = 1'b0;
      end
      checks++;
      if (pkt_done !== exp_done) begin
        failures++;
        $display("FAIL pkt_done: got=%b want=%b", pkt_done, exp_done);
      end
      if (pkt_done) dones++;
      oh = (own >= 0) ? (4'b0001 << own) : 4'b0;
      checks++;
      if (grant !== oh) begin
        failures++;
        $display("FAIL grant: got=%b want=%b", grant, oh);
      end
      exp_busy = (own >= 0) && (own_len != 0);
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy: got=%b want=%b", busy, exp_busy);
      end
      exp_ready = (own >= 0 && !hdr_pend && remaining > 0 && !tx_full)
                  ? oh : 4'b0;
      checks++;
      if (src_ready !== exp_ready) begin
        failures++;
        $display("FAIL src_ready: got=%b want=%b", src_ready, exp_ready);
      end
      exp_wr = (own >= 0) && (own_len != 0) && !tx_full &&
               (hdr_pend || (remaining > 0 && src_valid[own]));
      checks++;
      if (wr_en !== exp_wr) begin
        failures++;
        $display("FAIL wr_en: got=%b want=%b full=%b",
                 wr_en, exp_wr, tx_full);
      end
      if (wr_en === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL wr_data: got=%h want=<none>", wr_data);
        end else begin
          e = expq.pop_front();
          if (wr_data !== e) begin
            failures++;
            $display("FAIL wr_data: got=%h want=%h", wr_data, e);
          end
        end
        n_writes++;
        if (first_wr < 0) first_wr = it;
        last_wr = it;
        if (hdr_pend) begin
          hdr_pend = 0;
          if (prev_last_wr >= 0) begin
            if (it - prev_last_wr < min_turn) min_turn = it - prev_last_wr;
            if (it - prev_last_wr > max_turn) max_turn = it - prev_last_wr;
          end
        end else if (remaining > 0) begin
          remaining--;
          pkt_wr++;
          if (drop_mode == 2 && pkt_wr == 1) req[own] = 1'b0;
          if (bp_burst && pkt_wr == 2) begin
            bp_left = 5;
            bp_burst = 0;
          end
        end
        if (own >= 0 && remaining == 0 && !hdr_pend) begin
          done_due = 1;
          prev_last_wr = it;
          own = -1;
        end
      end else if (own < 0) begin
        checks++;
        if (wr_data !== 8'h00) begin
          failures++;
          $display("FAIL wr_data_idle: got=%h want=00", wr_data);
        end
      end
      if (own >= 0 && own_len == 0) own = -1;
      for (int i = 0; i < 4; i++)
        if (src_ready[i] && src_valid[i]) ptr[i]++;
      if (stop_pw > 0 && pkt_wr >= stop_pw) break;
    end
    if (it >= 4000) begin
      checks++;
      failures++;
      $display("FAIL timeout: dones=%0d want=%0d", dones, npkts);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({grant, busy, pkt_done, src_ready, wr_en, wr_data} !== 19'b0) begin
      failures++;
      $display("FAIL %s: grant=%b busy=%b done=%b rdy=%b wr=%b data=%h want all 0",
               tag, grant, busy, pkt_done, src_ready, wr_en, wr_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0;
    req_len = 16'h0;
    src_valid = 4'b0;
    src_data = 32'h0;
    tx_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ptr[i] = 0;
      for (int k = 0; k < 256; k++) payload[i][k] = 8'($urandom);
    end
    drop_mode = 0;
    bp_burst = 0;
    bp_left = 0;
    stop_pw = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    payload[0][ptr[0] & 255]       = 8'hA1;
    payload[0][(ptr[0] + 1) & 255] = 8'hA2;
    payload[0][(ptr[0] + 2) & 255] = 8'hA3;
    set_lens(3, 0, 0, 0);
    req = 4'b0001;
    drop_mode = 1;
    run(1, 3, 0, 0);
    checks++;
    if (n_writes !== 4 || last_wr - first_wr !== 3) begin
      failures++;
      $display("FAIL single_burst: writes=%0d span=%0d want 4/3",
               n_writes, last_wr - first_wr);
    end
    checks++;
    if (first_grant_iter !== 0) begin
      failures++;
      $display("FAIL arb_latency: got=%0d want=0", first_grant_iter);
    end
  endtask

  task automatic test_round_robin();
    set_lens(1, 1, 1, 1);
    req = 4'b1011;
    drop_mode = 0;
    run(6, 0, 0, 0);
    req = 4'b0;
    checks++;
    if (min_turn !== 2 || max_turn !== 2) begin
      failures++;
      $display("FAIL turnaround: min=%0d max=%0d want 2", min_turn, max_turn);
    end
  endtask

  task automatic test_backpressure();
    set_lens(0, 0, 8, 0);
    req = 4'b0100;
    drop_mode = 1;
    bp_burst = 1;
    run(1, 2, 0, 0);
    checks++;
    if (full_seen !== 5 || n_writes !== 9) begin
      failures++;
      $display("FAIL backpressure: full_cycles=%0d writes=%0d want 5/9",
               full_seen, n_writes);
    end
  endtask

  task automatic test_gaps_drop();
    set_lens(0, 2, 0, 0);
    req = 4'b0010;
    drop_mode = 2;
    run(1, 4, 0, 50);
    checks++;
    if (n_writes !== 3) begin
      failures++;
      $display("FAIL gaps_drop: writes=%0d want=3", n_writes);
    end
  endtask

  task automatic test_len_zero();
    set_lens(1, 1, 0, 1);
    req = 4'b0100;
    drop_mode = 1;
    run(1, 1, 0, 0);
    checks++;
    if (n_writes !== 0) begin
      failures++;
      $display("FAIL len_zero_writes: got=%0d want=0", n_writes);
    end
    set_lens(1, 1, 1, 1);
    req = 4'b1111;
    drop_mode = 0;
    run(4, 0, 0, 0);
    req = 4'b0;
    checks++;
    if (first_w !== 3) begin
      failures++;
      $display("FAIL len_zero_next: first=%0d want=3", first_w);
    end
  endtask

  task automatic test_reset_mid();
    set_lens(5, 0, 0, 0);
    req = 4'b0001;
    drop_mode = 1;
    stop_pw = 2;
    run(1, 0, 0, 0);
    stop_pw = 0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_lens(2, 3, 1, 4);
    req = 4'b1111;
    drop_mode = 0;
    run(4, 0, 0, 0);
    req = 4'b0;
    checks++;
    if (first_w !== 0) begin
      failures++;
      $display("FAIL reset_first_grant: got=%0d want=0", first_w);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      req = 4'($urandom_range(15, 1));
      req_len = 16'($urandom);
      drop_mode = 0;
      run(6, 0, 20, 20);
      req = 4'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_gaps_drop();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
